// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 4-bit restoring divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package div_pkg;

    localparam int WIDTH = 4;

    // Quotient reported for a zero divisor (all ones).
    localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/add_sub.sv
// 4-bit adder/subtractor: i_s=0 gives a+b, i_s=1 gives a-b in two's complement.
// Latency: combinational, zero cycles.
// Backpressure: none; purely combinational.
//
// Ports:
//   i_a, i_b : operands
//   i_s      : 0 = add, 1 = subtract
//   o_sum    : low WIDTH bits of the result
//   o_cout   : carry out; in subtract mode 1 means no borrow (a >= b)
module add_sub
    import div_pkg::*;
(
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_s,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH:0] full_sum;

    // Subtract as a + ~b + 1; the +1 rides in on i_s.
    assign full_sum = {1'b0, i_a}
                    + {1'b0, i_b ^ {WIDTH{i_s}}}
                    + {{WIDTH{1'b0}}, i_s};

    assign o_sum  = full_sum[WIDTH-1:0];
    assign o_cout = full_sum[WIDTH];

endmodule

// File: rtl/div_4bit_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Latency: done pulse follows the start edge by 5 edges (1 edge for a zero divisor).
// Backpressure: none; i_start is only sampled in IDLE and ignored otherwise.
//
// Ports:
//   i_clk, i_rst_n          : clock (rising edge), async active-low reset
//   i_start                 : start request, accepted in IDLE only
//   i_dividend, i_divisor   : operands, captured on the accepted start edge
//   o_busy                  : high while iterating
//   o_done                  : one-cycle pulse when results become valid
//   o_quotient, o_remainder : results, held until the next completion
//   o_div_zero              : divisor was zero, held with the results
module div_4bit_seq
    import div_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_zero
);

    div_state_t       state_q;
    logic [1:0]       cnt_q;
    logic [WIDTH:0]   r_q;      // partial remainder, one guard bit
    logic [WIDTH-1:0] q_q;      // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] d_q;      // captured divisor

    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] q_shift;
    logic [WIDTH-1:0] sub_sum;
    logic             sub_cout;
    logic             sub_ok;
    logic [WIDTH:0]   r_nxt;
    logic [WIDTH-1:0] q_nxt;

    // The trial subtraction; the only subtractor in the datapath.
    add_sub u_sub (
        .i_a    (r_shift[WIDTH-1:0]),
        .i_b    (d_q),
        .i_s    (1'b1),
        .o_sum  (sub_sum),
        .o_cout (sub_cout)
    );

    always_comb begin
        r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        q_shift = {q_q[WIDTH-2:0], 1'b0};
        // A set guard bit means the shifted remainder exceeds any 4-bit divisor,
        // so the subtract succeeds even though the 4-bit adder reports a borrow.
        sub_ok  = r_shift[WIDTH] | sub_cout;
        if (sub_ok) begin
            r_nxt = {1'b0, sub_sum};
            q_nxt = {q_shift[WIDTH-1:1], 1'b1};
        end else begin
            r_nxt = r_shift;
            q_nxt = q_shift;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
            o_div_zero  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_divisor != '0) begin
                            d_q     <= i_divisor;
                            q_q     <= i_dividend;
                            r_q     <= '0;
                            cnt_q   <= 2'd0;
                            o_busy  <= 1'b1;
                            state_q <= ST_CALC;
                        end else begin
                            // Zero divisor short-circuits straight to the result.
                            o_quotient  <= DIV0_QUOTIENT;
                            o_remainder <= i_dividend;
                            o_div_zero  <= 1'b1;
                            o_done      <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_CALC: begin
                    r_q   <= r_nxt;
                    q_q   <= q_nxt;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        o_quotient  <= q_nxt;
                        o_remainder <= r_nxt[WIDTH-1:0];
                        o_div_zero  <= 1'b0;
                        o_busy      <= 1'b0;
                        o_done      <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    o_done  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_4bit_seq.sv
// Directed self-checking bench for the sequential 4-bit divider.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_div_4bit_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;

    int checks   = 0;
    int failures = 0;

    div_4bit_seq dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_dividend  (dividend),
        .i_divisor   (divisor),
        .o_busy      (busy),
        .o_done      (done),
        .o_quotient  (quotient),
        .o_remainder (remainder),
        .o_div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE and check it through to the return to IDLE.
    // Called 1 time unit after an edge; returns 1 time unit after the DONE->IDLE edge,
    // so a following call is back-to-back.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] exp_q, input logic [3:0] exp_r,
                          input logic exp_dz, input string tag);
        int waited;
        int busy_cnt;
        bit seen;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        step();                 // accept edge N
        start    = 1'b0;
        dividend = 4'h0;
        divisor  = 4'h0;
        waited   = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (busy && done) check({tag, " busy_and_done"}, 32'd1, 32'd0);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            waited++;
            step();
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(waited), (b == 4'd0) ? 32'd0 : 32'd4);
        check({tag, " busy_cycles"}, 32'(busy_cnt), (b == 4'd0) ? 32'd0 : 32'd4);
        check({tag, " quotient"}, 32'(quotient), 32'(exp_q));
        check({tag, " remainder"}, 32'(remainder), 32'(exp_r));
        check({tag, " div_zero"}, 32'(div_zero), 32'(exp_dz));
        step();                 // DONE -> IDLE
        check({tag, " done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int done_cnt;
        logic [3:0] eq;
        logic [3:0] er;
        logic       ez;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 4'h0;
        divisor  = 4'h0;
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset quotient", 32'(quotient), 32'd0);
        check("reset remainder", 32'(remainder), 32'd0);
        check("reset div_zero", 32'(div_zero), 32'd0);
        rst_n = 1'b1;
        step();

        run_op(4'd13, 4'd4,  4'd3,  4'd1, 1'b0, "13/4");
        run_op(4'd15, 4'd1,  4'd15, 4'd0, 1'b0, "15/1");
        run_op(4'd3,  4'd7,  4'd0,  4'd3, 1'b0, "3/7");
        run_op(4'd15, 4'd15, 4'd1,  4'd0, 1'b0, "15/15");
        run_op(4'd9,  4'd0,  4'd15, 4'd9, 1'b1, "9/0");

        // 12/5 with start held high (15/1) through CALC and DONE: must be ignored.
        start    = 1'b1;
        dividend = 4'd12;
        divisor  = 4'd5;
        step();                 // accept edge N
        dividend = 4'd15;
        divisor  = 4'd1;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin   // edges N+1 .. N+5
            step();
            if (done) done_cnt++;
        end
        start    = 1'b0;
        dividend = 4'h0;
        divisor  = 4'h0;
        check("ignore done_count", 32'(done_cnt), 32'd1);
        check("ignore quotient", 32'(quotient), 32'd2);
        check("ignore remainder", 32'(remainder), 32'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold quotient", 32'(quotient), 32'd2);
            check("hold remainder", 32'(remainder), 32'd2);
            check("hold busy", 32'(busy), 32'd0);
            check("hold done", 32'(done), 32'd0);
        end

        // 14/3 aborted by reset after two CALC cycles.
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd3;
        step();
        start    = 1'b0;
        step();
        step();
        check("abort busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort quotient", 32'(quotient), 32'd0);
        check("abort remainder", 32'(remainder), 32'd0);
        check("abort div_zero", 32'(div_zero), 32'd0);
        step();
        check("abort no_done", 32'(done), 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        check("post_reset idle done", 32'(done), 32'd0);
        run_op(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, "14/3 after reset");

        // Exhaustive sweep, back-to-back.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    eq = 4'hF;
                    er = 4'(a);
                    ez = 1'b1;
                end else begin
                    eq = 4'(a / b);
                    er = 4'(a % b);
                    ez = 1'b0;
                end
                run_op(4'(a), 4'(b), eq, er, ez, "sweep");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_4bit_seq.md
# div_4bit_seq

Sequential 4-bit unsigned restoring divider. It computes the quotient and remainder of a 4-bit dividend by a 4-bit divisor, one quotient bit per clock. Each trial subtraction is done by the existing 4-bit `add_sub` block in subtract mode. This is the iterative counterpart to the combinational add/sub datapath, for arithmetic units that need division.

## Interface

- `WIDTH`, 4: operand width. Fixed at 4 because it is tied to the `add_sub` width. Localparam, not overridable.
- `i_clk`  input  1: single clock, rising edge.
- `i_rst_n`  input  1: asynchronous active-low reset.
- `i_start`  input  1: start request. Sampled only in IDLE.
- `i_dividend`  input  4: unsigned dividend. Captured on the accepted start edge.
- `i_divisor`  input  4: unsigned divisor. Captured on the accepted start edge.
- `o_busy`  output  1: high while in CALC.
- `o_done`  output  1: one-cycle pulse when results are valid.
- `o_quotient`  output  4: quotient. Held until the next accepted start.
- `o_remainder`  output  4: remainder. Held until the next accepted start.
- `o_div_zero`  output  1: divisor was zero. Valid with `o_done`, held with the results.

## Operation

- States:
  - IDLE: waits for start.
  - CALC: performs 4 iterations.
  - DONE: one cycle, `o_done`=1.
- Reset (async, any state): state=IDLE. All outputs are 0. Internal R, Q, D and the counter are cleared.
- IDLE with `i_start`=1 and divisor≠0:
  - D←divisor, Q←dividend, R←0 (5 bits), count←0.
  - Go to CALC.
- IDLE with `i_start`=1 and divisor=0:
  - Go directly to DONE.
  - `o_quotient`=4'hF, `o_remainder`=dividend, `o_div_zero`=1.
- CALC iteration, each cycle:
  - Shift: Rs={R[3:0],Q[3]}, Qs={Q[2:0],1'b0}.
  - `add_sub` with i_a=Rs[3:0], i_b=D, i_s=1 gives sum and cout. cout=1 means no borrow.
  - ok = Rs[4] | cout.
  - If ok: R←{1'b0,sum} and Q←{Qs[3:1],1'b1}.
  - Else: R←Rs and Q←Qs.
  - count++.
  - On the 4th iteration (count==3), go to DONE, loading `o_quotient`←new Q, `o_remainder`←new R[3:0], `o_div_zero`←0.
- DONE: go to IDLE on the next edge. `o_done` returns to 0 and the results stay held.
- `i_start` in CALC or DONE is ignored. It is not queued.
- Arithmetic is unsigned only. The invariant remainder < divisor always holds on non-zero divide, so R[4] is never set after a successful subtract.

## Timing

- Start accepted at edge N:
  - `o_busy`=1 in cycles N+1..N+4.
  - `o_done`=1 in the cycle after edge N+4.
  - Results are valid from then on.
  - Latency is 5 edges from start to the done edge.
- Divide by zero: `o_done`=1 in the cycle after edge N. `o_busy` never rises.
- Back-to-back: the earliest next start is accepted on the edge that returns to IDLE + 1, so one op costs 6 cycles.
- `o_busy` and `o_done` are never high together.
- Reset asserted mid-CALC: everything is 0 immediately. No `o_done` is produced for the aborted op.
- Inputs only need to be stable at the accepting edge.

## Structure

- Package `div_pkg`:
  - state enum (IDLE, CALC, DONE)
  - `WIDTH`=4
  - `DIV0_QUOTIENT`=4'hF
- One sub-module: the existing `add_sub` (4-bit, i_s tied to 1), instance `u_sub`. It is the only subtractor.
- Sequential logic in this module: the FSM, a 2-bit counter, and the R/Q/D registers.

## Test plan

- 13÷4, start pulse → `o_done` 5 edges later with Q=3, R=1, div_zero=0. `o_busy` is high for exactly 4 cycles.
- 15÷1 → Q=15, R=0. Also 3÷7 → Q=0, R=3. Also 15÷15 → Q=1, R=0.
- 9÷0 → `o_done` in the cycle after the start edge, Q=15, R=9, div_zero=1, `o_busy` never 1.
- Start 12÷5. Pulse `i_start` with 15÷1 during CALC and DONE → only one `o_done`, with Q=2, R=2. Results hold at 2/2 for 3 further idle cycles.
- Start 14÷3. Assert `i_rst_n`=0 after 2 CALC cycles → outputs 0 immediately. After release, a new 14÷3 gives Q=4, R=2.
- Exhaustive: all 256 operand pairs back-to-back → results match a/b and a%b, with div-zero rules for b=0.
